ptw_mem_responder: RTL and testbench
====================================

Name: ptw_mem_responder

Overview:
- Memory-side responder for the Sv39 page-table walker's PTE read port.
- Accepts the walker's level-by-level PTE reads (mem_req/mem_addr) and issues each as a 64-bit read on the data bus.
- Returns the PTE with a one-cycle pte_valid pulse.
- Sits between the walker in the memory stage and the dbus arbiter.

Parameters:
- CACHE_ENTRIES, 4, number of PTE cache entries; power of 2, range 2..16; used only with PTW_PTE_CACHE_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_req  in  1  walker requests a PTE read; held high while the walker waits
- mem_addr  in  64  physical PTE address; sampled on acceptance
- flush  in  1  satp write or sfence.vma; single-cycle pulse
- pte  out  64  returned PTE; valid only while pte_valid is high
- pte_valid  out  1  one-cycle response pulse
- bus_req_valid  out  1  bus read request valid
- bus_req_addr  out  64  bus request address
- bus_req_size  out  3  constant 3'b011 (8 bytes)
- bus_req_strobe  out  8  constant 0 (read)
- bus_resp_addr_ok  in  1  bus accepted the address
- bus_resp_data_ok  in  1  bus read data valid
- bus_resp_data  in  64  bus read data

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE; pte=0; pte_valid=0; bus_req_valid=0; bus_req_addr=0; drop flag=0.
- States: IDLE, REQ, WAIT, RESP, GAP.
- IDLE:
  - If mem_req=1, latch mem_addr into addr_q.
  - If mem_addr[2:0]!=0 (misaligned): pte_q=0 and go to RESP. The walker sees a PTE with V=0 and treats it as a fault. No bus access.
  - Otherwise go to REQ.
- REQ:
  - bus_req_valid=1, bus_req_addr=addr_q.
  - Stay until bus_resp_addr_ok=1, then go to WAIT.
  - The request is held even if mem_req drops; it is never withdrawn before addr_ok.
- WAIT:
  - On bus_resp_data_ok=1, capture pte_q=bus_resp_data.
  - Go to RESP if the drop flag is clear; go to GAP if it is set.
  - If data_ok arrives in the same cycle as addr_ok, it is not accepted. The bus never does this.
- RESP: pte_valid=1 and pte=pte_q for exactly one cycle, then GAP.
- GAP:
  - One idle cycle, then IDLE.
  - This lets the walker update mem_addr for the next level while mem_req stays high.
  - No request is accepted during RESP or GAP.
- Drop flag:
  - Set when mem_req=0 in REQ or WAIT.
  - Cleared on entry to IDLE.
  - An abandoned transaction completes on the bus silently, with no pte_valid.
- Latency (miss path): accept at cycle T; bus_req_valid high from T+1; data_ok at cycle D; pte_valid at D+1.
- Misaligned latency: pte_valid at T+1.
- Back-to-back: the next acceptance is at the earliest two cycles after the pte_valid pulse.
- flush: has no effect on the bus FSM. An outstanding read completes normally.
- Reset mid-transaction: returns to IDLE immediately and bus_req_valid drops. The bus arbiter treats reset as global, so there are no stale data_ok pulses.
- pte is a registered output. pte_valid is asserted only in RESP.

Optional Feature:
- Macro: PTW_PTE_CACHE_EN.
- With the macro defined:
  - Fully associative PTE cache of CACHE_ENTRIES entries. Each entry holds {valid, tag=addr[63:3], data[63:0]}.
  - Lookup in IDLE. On a hit, pte_q=data, go directly to RESP (pte_valid at T+1), no bus access.
  - Fill on every non-dropped data_ok, but only if bus_resp_data[0]=1 (V bit set). The victim is chosen by a round-robin pointer that advances per fill.
  - flush clears all valid bits in the same cycle. If flush and a fill coincide, flush wins: the entry ends invalid.
  - A drop-abandoned response is not filled.
- Without the macro: no cache storage, CACHE_ENTRIES is ignored, every aligned request goes to the bus.

Decomposition:
- Package ptw_pkg holds:
  - state enum ptw_resp_state_t
  - PTE field constants: PTE_V=0, PTE_R=1, PTE_W=2, PTE_X=3, PPN_LSB=10, PPN_MSB=53
  - BUS_SIZE_8B = 3'b011
  - struct pte_cache_entry_t
- Sub-module ptw_pte_cache, instantiated only under PTW_PTE_CACHE_EN:
  - lookup port (addr, hit, data)
  - fill port (en, addr, data)
  - flush input
  - internal round-robin pointer

Test Plan:
- Single read: mem_req=1, mem_addr=0x8000_2008; bus addr_ok after 2 cycles, data_ok 3 cycles later with data 0x2000_0C01 -> bus_req_addr=0x8000_2008, size=3, strobe=0; one pte_valid pulse with pte=0x2000_0C01.
- Three-level walk: three sequential reads at 0x8000_1010, 0x8000_3FF8, 0x8000_4000 with mem_req held high -> three pulses, each followed by a GAP cycle, and three distinct bus requests in order.
- Misaligned: mem_addr=0x8000_2004 -> pte_valid at T+1 with pte=0, and bus_req_valid never asserted.
- Abandon: mem_req drops during WAIT -> the bus read still completes and no pte_valid is seen. A new request at 0x8000_5000 is then served correctly.
- Reset mid-WAIT: reset for 1 cycle -> all outputs return to 0 and state is IDLE; the next request is served normally.
- Cache (PTW_PTE_CACHE_EN):
  - Read 0x8000_2008 twice -> the second read makes no bus request and pte_valid arrives at T+1.
  - flush, then read 0x8000_2008 again -> the bus request reappears.
  - Fill with data bit0=0 -> a repeat read still misses.

Source files
------------

// File: rtl/ptw_pkg.sv
// Shared types and constants for the Sv39 PTW memory responder.
// The PTE cache entry type is used only when PTW_PTE_CACHE_EN is defined.
package ptw_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StResp,
    StGap
  } ptw_resp_state_t;

  localparam int unsigned PTE_V   = 0;
  localparam int unsigned PTE_R   = 1;
  localparam int unsigned PTE_W   = 2;
  localparam int unsigned PTE_X   = 3;
  localparam int unsigned PPN_LSB = 10;
  localparam int unsigned PPN_MSB = 53;

  localparam logic [2:0] BUS_SIZE_8B = 3'b011;

  typedef struct packed {
    logic        valid;
    logic [60:0] tag;
    logic [63:0] data;
  } pte_cache_entry_t;

endpackage

// File: rtl/ptw_pte_cache.sv
// Fully associative PTE cache with round-robin replacement.
// Instantiated by ptw_mem_responder only when PTW_PTE_CACHE_EN is defined.
module ptw_pte_cache
  import ptw_pkg::*;
#(
  parameter int unsigned Entries = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [60:0] lookup_tag,
  output logic        lookup_hit,
  output logic [63:0] lookup_data,
  input  logic        fill_en,
  input  logic [60:0] fill_tag,
  input  logic [63:0] fill_data
);

  localparam int unsigned PtrW = $clog2(Entries);

  pte_cache_entry_t entries_q [Entries];
  logic [PtrW-1:0]  ptr_q;

  // A lookup coinciding with flush must not return a stale translation.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < Entries; i++) begin
      if (entries_q[i].valid && entries_q[i].tag == lookup_tag && !flush) begin
        lookup_hit  = 1'b1;
        lookup_data = entries_q[i].data;
      end
    end
  end

  // Flush is written last so it overrides a fill in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      for (int i = 0; i < Entries; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      if (fill_en) begin
        entries_q[ptr_q] <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
        ptr_q            <= ptr_q + PtrW'(1);
      end
      if (flush) begin
        for (int i = 0; i < Entries; i++) begin
          entries_q[i].valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/ptw_mem_responder.sv
// Serves page-table walker PTE reads over the 64-bit data bus, one pte_valid pulse per read.
// Optional PTE cache enabled by defining PTW_PTE_CACHE_EN.
module ptw_mem_responder
  import ptw_pkg::*;
#(
  parameter int unsigned CACHE_ENTRIES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic [63:0] mem_addr,
  input  logic        flush,
  output logic [63:0] pte,
  output logic        pte_valid,
  output logic        bus_req_valid,
  output logic [63:0] bus_req_addr,
  output logic [2:0]  bus_req_size,
  output logic [7:0]  bus_req_strobe,
  input  logic        bus_resp_addr_ok,
  input  logic        bus_resp_data_ok,
  input  logic [63:0] bus_resp_data
);

  ptw_resp_state_t state_q;
  logic [63:0]     addr_q;
  logic            drop_q;

  logic            misaligned;
  logic            drop_now;
  logic            cache_hit;
  logic [63:0]     cache_data;

  assign misaligned     = (mem_addr[2:0] != 3'b000);
  // A walker that lets go in the data_ok cycle itself has also abandoned the read.
  assign drop_now       = drop_q | ~mem_req;
  assign bus_req_addr   = addr_q;
  assign bus_req_size   = BUS_SIZE_8B;
  assign bus_req_strobe = 8'h00;

`ifdef PTW_PTE_CACHE_EN
  logic fill_en;

  assign fill_en = (state_q == StWait) && bus_resp_data_ok && !drop_now &&
                   bus_resp_data[PTE_V];

  ptw_pte_cache #(
    .Entries(CACHE_ENTRIES)
  ) u_pte_cache (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .lookup_tag (mem_addr[63:3]),
    .lookup_hit (cache_hit),
    .lookup_data(cache_data),
    .fill_en    (fill_en),
    .fill_tag   (addr_q[63:3]),
    .fill_data  (bus_resp_data)
  );
`else
  logic [5:0] unused_cache_cfg;

  assign cache_hit        = 1'b0;
  assign cache_data       = '0;
  assign unused_cache_cfg = {flush, 5'(CACHE_ENTRIES)};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      drop_q        <= 1'b0;
      pte           <= '0;
      pte_valid     <= 1'b0;
      bus_req_valid <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (mem_req) begin
            addr_q <= mem_addr;
            if (misaligned) begin
              // V=0 makes the walker raise a page fault.
              pte       <= '0;
              pte_valid <= 1'b1;
              state_q   <= StResp;
            end else if (cache_hit) begin
              pte       <= cache_data;
              pte_valid <= 1'b1;
              state_q   <= StResp;
            end else begin
              bus_req_valid <= 1'b1;
              state_q       <= StReq;
            end
          end
        end
        StReq: begin
          if (!mem_req) drop_q <= 1'b1;
          if (bus_resp_addr_ok) begin
            bus_req_valid <= 1'b0;
            state_q       <= StWait;
          end
        end
        StWait: begin
          if (!mem_req) drop_q <= 1'b1;
          if (bus_resp_data_ok) begin
            if (drop_now) begin
              state_q <= StGap;
            end else begin
              pte       <= bus_resp_data;
              pte_valid <= 1'b1;
              state_q   <= StResp;
            end
          end
        end
        StResp: begin
          pte_valid <= 1'b0;
          state_q   <= StGap;
        end
        StGap: begin
          drop_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ptw_mem_responder.sv
// Directed bench for ptw_mem_responder; cache checks run when PTW_PTE_CACHE_EN is defined.
module tb_ptw_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        flush;
  logic [63:0] pte;
  logic        pte_valid;
  logic        bus_req_valid;
  logic [63:0] bus_req_addr;
  logic [2:0]  bus_req_size;
  logic [7:0]  bus_req_strobe;
  logic        bus_resp_addr_ok;
  logic        bus_resp_data_ok;
  logic [63:0] bus_resp_data;

  int          tests  = 0;
  int          failed = 0;
  int          pv_cnt = 0;
  int          breq_cnt = 0;
  logic [63:0] breq_log [16];
  logic        prev_brv = 1'b0;
  int          base_breq;

  always #5 clk = ~clk;

  ptw_mem_responder #(
    .CACHE_ENTRIES(4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .flush           (flush),
    .pte             (pte),
    .pte_valid       (pte_valid),
    .bus_req_valid   (bus_req_valid),
    .bus_req_addr    (bus_req_addr),
    .bus_req_size    (bus_req_size),
    .bus_req_strobe  (bus_req_strobe),
    .bus_resp_addr_ok(bus_resp_addr_ok),
    .bus_resp_data_ok(bus_resp_data_ok),
    .bus_resp_data   (bus_resp_data)
  );

  // Advance to the next falling edge and log pulses and new bus requests.
  task automatic tick();
    @(negedge clk);
    if (pte_valid) pv_cnt++;
    if (bus_req_valid && !prev_brv) begin
      if (breq_cnt < 16) breq_log[breq_cnt] = bus_req_addr;
      breq_cnt++;
    end
    prev_brv = bus_req_valid;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full miss-path read; starts and ends at a falling edge with the DUT in IDLE.
  task automatic bus_read(input string tag, input logic [63:0] a, input logic [63:0] d,
                          input int addr_lat, input int data_lat);
    mem_req  = 1'b1;
    mem_addr = a;
    tick();
    chk({tag, " req_valid"}, 64'(bus_req_valid), 64'd1);
    chk({tag, " req_addr"}, bus_req_addr, a);
    repeat (addr_lat - 1) tick();
    bus_resp_addr_ok = 1'b1;
    tick();
    bus_resp_addr_ok = 1'b0;
    chk({tag, " req_dropped"}, 64'(bus_req_valid), 64'd0);
    repeat (data_lat - 1) tick();
    bus_resp_data_ok = 1'b1;
    bus_resp_data    = d;
    tick();
    bus_resp_data_ok = 1'b0;
    chk({tag, " pte_valid"}, 64'(pte_valid), 64'd1);
    chk({tag, " pte"}, pte, d);
    tick();
    chk({tag, " gap"}, 64'(pte_valid), 64'd0);
    tick();
  endtask

  initial begin
    reset            = 1'b1;
    mem_req          = 1'b0;
    mem_addr         = '0;
    flush            = 1'b0;
    bus_resp_addr_ok = 1'b0;
    bus_resp_data_ok = 1'b0;
    bus_resp_data    = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst pte", pte, 64'd0);
    chk("rst pte_valid", 64'(pte_valid), 64'd0);
    chk("rst req_valid", 64'(bus_req_valid), 64'd0);
    chk("rst req_addr", bus_req_addr, 64'd0);
    chk("size", 64'(bus_req_size), 64'd3);
    chk("strobe", 64'(bus_req_strobe), 64'd0);

    // Single read
    bus_read("single", 64'h8000_2008, 64'h2000_0C01, 2, 3);
    mem_req = 1'b0;
    chk("single pulses", 64'(pv_cnt), 64'd1);
    chk("single breqs", 64'(breq_cnt), 64'd1);

    // Three-level walk with mem_req held high
    bus_read("walk1", 64'h8000_1010, 64'h2000_0401, 1, 1);
    bus_read("walk2", 64'h8000_3FF8, 64'h2000_0801, 3, 2);
    bus_read("walk3", 64'h8000_4000, 64'h2000_0CCF, 1, 2);
    mem_req = 1'b0;
    chk("walk pulses", 64'(pv_cnt), 64'd4);
    chk("walk breqs", 64'(breq_cnt), 64'd4);
    chk("walk log1", breq_log[1], 64'h8000_1010);
    chk("walk log2", breq_log[2], 64'h8000_3FF8);
    chk("walk log3", breq_log[3], 64'h8000_4000);

    // Misaligned: immediate V=0 response, no bus activity
    mem_req  = 1'b1;
    mem_addr = 64'h8000_2004;
    tick();
    mem_req = 1'b0;
    chk("mis pte_valid", 64'(pte_valid), 64'd1);
    chk("mis pte", pte, 64'd0);
    chk("mis req_valid", 64'(bus_req_valid), 64'd0);
    tick();
    tick();
    chk("mis pulses", 64'(pv_cnt), 64'd5);
    chk("mis breqs", 64'(breq_cnt), 64'd4);

    // Abandon during WAIT
    mem_req  = 1'b1;
    mem_addr = 64'h8000_6000;
    tick();
    bus_resp_addr_ok = 1'b1;
    tick();
    bus_resp_addr_ok = 1'b0;
    mem_req          = 1'b0;
    tick();
    tick();
    bus_resp_data_ok = 1'b1;
    bus_resp_data    = 64'h1234_0001;
    tick();
    bus_resp_data_ok = 1'b0;
    chk("abandon no pulse", 64'(pte_valid), 64'd0);
    tick();
    chk("abandon pulses", 64'(pv_cnt), 64'd5);
    bus_read("after_abandon", 64'h8000_5000, 64'h2000_1001, 2, 1);
    mem_req = 1'b0;
    chk("after_abandon pulses", 64'(pv_cnt), 64'd6);

    // Reset while in WAIT
    mem_req  = 1'b1;
    mem_addr = 64'h8000_7000;
    tick();
    bus_resp_addr_ok = 1'b1;
    tick();
    bus_resp_addr_ok = 1'b0;
    reset   = 1'b1;
    mem_req = 1'b0;
    tick();
    reset = 1'b0;
    chk("midrst pte", pte, 64'd0);
    chk("midrst pte_valid", 64'(pte_valid), 64'd0);
    chk("midrst req_valid", 64'(bus_req_valid), 64'd0);
    chk("midrst req_addr", bus_req_addr, 64'd0);
    bus_read("post_rst", 64'h8000_8008, 64'h2000_2001, 1, 1);
    mem_req = 1'b0;
    chk("post_rst pulses", 64'(pv_cnt), 64'd7);

`ifdef PTW_PTE_CACHE_EN
    // Miss then hit on the same PTE address
    bus_read("c_miss", 64'h8000_2008, 64'h2000_0C01, 1, 1);
    mem_req   = 1'b0;
    base_breq = breq_cnt;
    mem_req   = 1'b1;
    mem_addr  = 64'h8000_2008;
    tick();
    mem_req = 1'b0;
    chk("c_hit pte_valid", 64'(pte_valid), 64'd1);
    chk("c_hit pte", pte, 64'h2000_0C01);
    chk("c_hit req_valid", 64'(bus_req_valid), 64'd0);
    tick();
    tick();
    chk("c_hit breqs", 64'(breq_cnt), 64'(base_breq));

    // Flush drops the entry
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus_read("c_flushed", 64'h8000_2008, 64'h2000_0C01, 1, 1);
    mem_req = 1'b0;

    // Invalid PTEs are never cached
    bus_read("c_inv1", 64'h8000_9000, 64'h2000_300E, 1, 1);
    mem_req = 1'b0;
    bus_read("c_inv2", 64'h8000_9000, 64'h2000_300E, 1, 1);
    mem_req = 1'b0;
    chk("c_breqs", 64'(breq_cnt), 64'(base_breq + 3));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
